// File: rtl/sram_ctrl_if.sv
// MEM-stage data-memory request/response bundle.
// The MEM stage is the master and the SRAM controller responds as the slave.
interface sram_ctrl_if;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_we_i;
    logic        mem_re_i;
    logic [3:0]  mem_mask_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;

    modport master (
        output mem_addr_i, mem_wdata_i, mem_we_i, mem_re_i, mem_mask_i,
        input  mem_rdata_o, mem_stall_o
    );

    modport slave (
        input  mem_addr_i, mem_wdata_i, mem_we_i, mem_re_i, mem_mask_i,
        output mem_rdata_o, mem_stall_o
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: turns MEM-stage requests into timed read/write cycles.
// The controller stalls MEM until each cycle completes.
//
// state | meaning
// IDLE  | waiting for a request; accepts and latches addr/mask/wdata
// READ  | oe_n low for RD_WAIT cycles, data captured on the last edge
// WRITE | we_n low for WR_WAIT cycles plus one data-hold cycle
// DONE  | one cycle of no strobes and no stall; read data valid
module sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        mem,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_data_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int CNT_MAX = (RD_WAIT > WR_WAIT + 1) ? RD_WAIT : WR_WAIT + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask_q;
    logic [31:0]      rdata_q;
    logic             accept;
    logic             cnt_tc;
    logic             unused_addr_bits;

    assign accept           = (state == IDLE) && (mem.mem_we_i || mem.mem_re_i);
    assign cnt_tc           = (cnt == '0);
    assign unused_addr_bits = ^{mem.mem_addr_i[31:ADDR_W+2], mem.mem_addr_i[1:0]};
    assign mem.mem_rdata_o  = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        mem.mem_stall_o = 1'b0;
        sram_ce_n       = 1'b1;
        sram_oe_n       = 1'b1;
        sram_we_n       = 1'b1;
        sram_be_n       = 4'hF;
        sram_data_oe    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    mem.mem_stall_o = 1'b1;
                    state_nxt       = mem.mem_we_i ? WRITE : READ;
                end
            end
            READ: begin
                mem.mem_stall_o = 1'b1;
                sram_ce_n       = 1'b0;
                sram_oe_n       = 1'b0;
                sram_be_n       = ~mask_q;
                if (cnt_tc) state_nxt = DONE;
            end
            WRITE: begin
                mem.mem_stall_o = 1'b1;
                sram_ce_n       = 1'b0;
                sram_data_oe    = 1'b1;
                sram_be_n       = ~mask_q;
                // last WRITE cycle releases we_n while data is still driven
                sram_we_n       = cnt_tc;
                if (cnt_tc) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            mask_q      <= 4'h0;
            sram_addr_o <= '0;
            sram_data_o <= 32'h0;
            rdata_q     <= 32'h0;
        end else begin
            if (accept) begin
                sram_addr_o <= mem.mem_addr_i[ADDR_W+1:2];
                mask_q      <= mem.mem_mask_i;
                sram_data_o <= mem.mem_wdata_i;
                cnt         <= mem.mem_we_i ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT - 1);
            end else if ((state == READ || state == WRITE) && !cnt_tc) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == READ && cnt_tc) rdata_q <= sram_data_i;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with hand-computed cycle-by-cycle expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_data_o;
    logic        sram_data_oe;
    logic [31:0] sram_data_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    sram_ctrl_if mem ();

    sram_ctrl #(.ADDR_W(20), .RD_WAIT(2), .WR_WAIT(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (mem.slave),
        .sram_addr_o  (sram_addr_o),
        .sram_data_o  (sram_data_o),
        .sram_data_oe (sram_data_oe),
        .sram_data_i  (sram_data_i),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    always #5 clk = ~clk;

    task automatic start_req(input logic we, input logic re, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wdata);
        @(posedge clk); #1;
        mem.mem_we_i    = we;
        mem.mem_re_i    = re;
        mem.mem_addr_i  = addr;
        mem.mem_mask_i  = mask;
        mem.mem_wdata_i = wdata;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem.mem_we_i = 1'b0; mem.mem_re_i = 1'b0; mem.mem_addr_i = 32'h0;
        mem.mem_mask_i = 4'h0; mem.mem_wdata_i = 32'h0; sram_data_i = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({mem.mem_stall_o, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe} !== 9'b0_1_1_1_1111_0)
            $display("FAIL reset_strobes got stall/ce/oe/we/be/oe=%b want 011111110", {mem.mem_stall_o, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe});
        else pass_cnt++;
        total_cnt++;
        if ({mem.mem_rdata_o, sram_addr_o, sram_data_o} !== 84'h0)
            $display("FAIL reset_regs got rdata=%h addr=%h wdata=%h want all 0", mem.mem_rdata_o, sram_addr_o, sram_data_o);
        else pass_cnt++;
    endtask

    task automatic test_read;
        sram_data_i = 32'hDEAD_BEEF;
        start_req(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (mem.mem_stall_o !== (c < 3)) $display("FAIL read_stall c=%0d got %b want %b", c, mem.mem_stall_o, c < 3);
            else pass_cnt++;
            total_cnt++;
            if (sram_oe_n !== !(c == 1 || c == 2)) $display("FAIL read_oe_n c=%0d got %b want %b", c, sram_oe_n, !(c == 1 || c == 2));
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (sram_be_n !== 4'h0) $display("FAIL read_be_n got %b want 0000", sram_be_n);
                else pass_cnt++;
                mem.mem_addr_i = 32'h8000_0FF0;
            end
            if (c == 2) begin
                total_cnt++;
                if (sram_addr_o !== 20'h00004) $display("FAIL read_addr got %h want 00004", sram_addr_o);
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if (mem.mem_rdata_o !== 32'hDEAD_BEEF) $display("FAIL read_rdata got %h want deadbeef", mem.mem_rdata_o);
                else pass_cnt++;
                mem.mem_re_i = 1'b0;
            end
        end
    endtask

    // Runs a write from the IDLE accept cycle through DONE; next_re selects a follow-on read in DONE.
    task automatic run_write(input string name, input logic re, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic next_re);
        logic [3:0] exp_be;
        start_req(1'b1, re, addr, mask, wdata);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_be = (c >= 1 && c <= 3) ? ~mask : 4'hF;
            total_cnt++;
            if (mem.mem_stall_o !== (c < 4)) $display("FAIL %s_stall c=%0d got %b want %b", name, c, mem.mem_stall_o, c < 4);
            else pass_cnt++;
            total_cnt++;
            if (sram_we_n !== !(c == 1 || c == 2)) $display("FAIL %s_we_n c=%0d got %b want %b", name, c, sram_we_n, !(c == 1 || c == 2));
            else pass_cnt++;
            total_cnt++;
            if (sram_data_oe !== (c >= 1 && c <= 3)) $display("FAIL %s_data_oe c=%0d got %b want %b", name, c, sram_data_oe, c >= 1 && c <= 3);
            else pass_cnt++;
            total_cnt++;
            if ({sram_oe_n, sram_be_n} !== {1'b1, exp_be}) $display("FAIL %s_oe_be c=%0d got %b_%b want 1_%b", name, c, sram_oe_n, sram_be_n, exp_be);
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if ({sram_addr_o, sram_data_o} !== {addr[21:2], wdata}) $display("FAIL %s_addr_data got %h/%h want %h/%h", name, sram_addr_o, sram_data_o, addr[21:2], wdata);
                else pass_cnt++;
            end
            if (c == 4) begin
                total_cnt++;
                if (mem.mem_rdata_o !== exp_rdata) $display("FAIL %s_rdata_kept got %h want %h", name, mem.mem_rdata_o, exp_rdata);
                else pass_cnt++;
                mem.mem_we_i = 1'b0;
                mem.mem_re_i = next_re;
                mem.mem_addr_i = 32'h8000_0020;
                mem.mem_mask_i = 4'hF;
            end
        end
    endtask

    task automatic test_byte_write;
        run_write("bwr", 1'b0, 32'h8000_0006, 4'b0100, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_we_re_priority;
        sram_data_i = 32'h1234_5678;
        run_write("wepri", 1'b1, 32'h8000_0040, 4'hF, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_zero_mask;
        run_write("zmask", 1'b0, 32'h8000_0008, 4'h0, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_back_to_back;
        sram_data_i = 32'hCAFE_F00D;
        run_write("b2b", 1'b0, 32'h8000_0004, 4'hF, 32'h7777_8888, 32'hDEAD_BEEF, 1'b1);
        for (int c = 5; c < 9; c++) begin
            @(negedge clk);
            total_cnt++;
            if (mem.mem_stall_o !== (c < 8)) $display("FAIL b2b_rd_stall c=%0d got %b want %b", c, mem.mem_stall_o, c < 8);
            else pass_cnt++;
            total_cnt++;
            if (sram_oe_n !== !(c == 6 || c == 7)) $display("FAIL b2b_rd_oe_n c=%0d got %b want %b", c, sram_oe_n, !(c == 6 || c == 7));
            else pass_cnt++;
            if (c == 8) begin
                total_cnt++;
                if ({sram_addr_o, mem.mem_rdata_o} !== {20'h00008, 32'hCAFE_F00D}) $display("FAIL b2b_rd_result got %h/%h want 00008/cafef00d", sram_addr_o, mem.mem_rdata_o);
                else pass_cnt++;
                mem.mem_re_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_write;
        start_req(1'b1, 1'b0, 32'h8000_0100, 4'hF, 32'hA5A5_A5A5);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sram_we_n !== 1'b0) $display("FAIL rstmid_pre_we_n got %b want 0", sram_we_n);
        else pass_cnt++;
        rst = 1'b1;
        mem.mem_we_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({sram_we_n, sram_ce_n, sram_oe_n, sram_data_oe, mem.mem_stall_o, sram_be_n} !== 9'b1_1_1_0_0_1111)
            $display("FAIL rstmid_strobes got we/ce/oe/doe/stall/be=%b want 111001111", {sram_we_n, sram_ce_n, sram_oe_n, sram_data_oe, mem.mem_stall_o, sram_be_n});
        else pass_cnt++;
        total_cnt++;
        if ({mem.mem_rdata_o, sram_addr_o, sram_data_o} !== 84'h0)
            $display("FAIL rstmid_regs got rdata=%h addr=%h wdata=%h want all 0", mem.mem_rdata_o, sram_addr_o, sram_data_o);
        else pass_cnt++;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({sram_ce_n, sram_we_n, mem.mem_stall_o} !== 3'b110) $display("FAIL rstmid_quiet c=%0d got ce/we/stall=%b want 110", c, {sram_ce_n, sram_we_n, mem.mem_stall_o});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_we_re_priority();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
